// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage: restoring radix-2, one
// quotient bit per cycle, stalls the pipeline until hi/lo are ready.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  input  logic        hold,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg, r_neg;

  logic [32:0] rem_shift, rem_diff, rem_nxt;
  logic [31:0] quo_nxt;
  logic        rem_unused;

  // Two's-complement magnitude; 0x80000000 wraps onto itself.
  function automatic logic [31:0] abs_wrap(input logic signed [31:0] v, input logic en);
    logic signed [31:0] m;
    m = (en && v < 0) ? -v : v;
    return $unsigned(m);
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    if (cnt == 5'd31) state_nxt = DONE;
        DONE:    if (!hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    done      = (state == DONE);
    stall_req = 1'b0;
    if (resetn && !cancel && ((state == IDLE && start) || state == CALC))
      stall_req = 1'b1;
  end

  // The remainder always stays below the divisor magnitude, so its top bit
  // never feeds the next shift.
  assign rem_unused = rem[32];
  assign rem_shift  = {rem[31:0], quo[31]};
  assign rem_diff   = rem_shift - {1'b0, dvs};
  assign rem_nxt    = rem_diff[32] ? rem_shift : rem_diff;
  assign quo_nxt    = {quo[30:0], ~rem_diff[32]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= 5'd0;
      rem   <= 33'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (!cancel) begin
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= 33'd0;
            quo   <= abs_wrap(dividend, sign);
            dvs   <= abs_wrap(divisor, sign);
            q_neg <= sign & (dividend[31] ^ divisor[31]);
            r_neg <= sign & dividend[31];
            cnt   <= 5'd0;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          // Results are captured from the final iteration on the way into DONE.
          if (cnt == 5'd31) begin
            lo <= neg_if(quo_nxt, q_neg);
            hi <= neg_if(rem_nxt[31:0], r_neg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
